ls155_arbiter: RTL
==================

Name: ls155_arbiter

Overview:
- Arbitrates two requesters for one SN74LS155 dual 2-to-4 decoder.
- Both decoder halves share the A/B select lines, so only one half may be strobed at a time.
- Requester 0 owns half 1 (_1Y*) and requester 1 owns half 2 (_2Y*).
- Latches the winner's address and sequences select-setup, enable strobe and hold. Sits directly in front of ls155 and drives all its control pins.

Parameters:
SETUP_CYCLES, 1, clocks that A/B are stable before G falls (legal range 1..15)
STROBE_CYCLES, 2, clocks that the selected G is held low (legal range 1..15)

Ports:
_CLK  input  1  system clock, rising-edge
_RST_N  input  1  asynchronous active-low reset
_REQ0  input  1  request from requester 0 (half 1)
_ADDR0  input  2  requester 0 output select, {B,A}
_ACK0  output  1  one-cycle completion pulse to requester 0
_REQ1  input  1  request from requester 1 (half 2)
_ADDR1  input  2  requester 1 output select, {B,A}
_ACK1  output  1  one-cycle completion pulse to requester 1
_A  output  1  decoder select A
_B  output  1  decoder select B
_1C  output  1  decoder half-1 C input
_1G  output  1  decoder half-1 enable, active low
_2C  output  1  decoder half-2 C input
_2G  output  1  decoder half-2 enable, active low
_BUSY  output  1  high whenever state is not IDLE

Behaviour:
- Reset: one clock, _CLK. Reset is asynchronous and active-low on _RST_N.
- All outputs are registered.
- Reset values: _A=0, _B=0, _1G=1, _2G=1, _1C=1, _2C=0, _ACK0=0, _ACK1=0, _BUSY=0. State=IDLE, round-robin pointer favours requester 0.
- Reset asserted mid-transaction: both G lines go high immediately (asynchronously). No ACK is issued. The pending request is re-arbitrated after reset release if REQ is still high.
- States: IDLE -> SETUP -> STROBE -> RELEASE -> IDLE.
- IDLE, at least one REQ sampled high at edge t0:
  - choose the winner, latch its ADDR onto {_B,_A}, go to SETUP.
  - counter loads SETUP_CYCLES-1.
- SETUP: G lines stay high. After SETUP_CYCLES clocks, at edge t0+SETUP_CYCLES:
  - winner's G goes low (_1G for requester 0, _2G for requester 1).
  - go to STROBE.
- STROBE: G stays low for exactly STROBE_CYCLES clocks. At edge t0+SETUP+STROBE:
  - G returns high, winner's ACK goes high, go to RELEASE.
- RELEASE: one clock. A/B are held (hold time). ACK drops, go to IDLE.
- Back-to-back transaction period is SETUP+STROBE+2 clocks (5 with defaults).
- The losing half's G is never low. _1G and _2G are never low simultaneously.
- Arbitration:
  - Single request: granted.
  - Both requests high in IDLE: the requester not granted most recently wins; the pointer updates on each grant.
  - Requester continuously high while the other is also high: grants strictly alternate.
- Handshake:
  - REQ and ADDR must be held until ACK; ADDR is sampled only at the grant edge.
  - ADDR changes after grant are ignored.
  - REQ dropped after grant: the transaction still completes and ACK still pulses.
  - REQ still high in the first IDLE cycle after RELEASE is a new request.
- _1C=1 and _2C=0 constantly (decoder mode), unless the optional feature below is compiled in.

Optional Feature:
- Macro: LS155_DEMUX_EN.
- Defined:
  - adds input ports _DATA0 (1) and _DATA1 (1), each latched with ADDR at grant.
  - during SETUP/STROBE/RELEASE of a requester-0 transaction, _1C = latched _DATA0.
  - during a requester-1 transaction, _2C = ~latched _DATA1.
  - so the selected output goes low only when data=1 (demultiplexer mode).
  - in IDLE, _1C=1 and _2C=0.
- Undefined: ports absent; _1C=1 and _2C=0 always.

Test Plan:
- Reset: hold _RST_N=0 with both REQs high -> _1G=_2G=1, _A=_B=0, _1C=1, _2C=0, ACKs=0, _BUSY=0.
- Single request: _REQ0=1, _ADDR0=2'b10 at t0 -> {_B,_A}=10 from t0+1; _1G low t0+1..t0+3; _ACK0 high t0+3 for one cycle; _BUSY low at t0+4; ls155 _1Y2=0 only during the strobe.
- Simultaneous requests: _REQ0=_REQ1=1 after reset, _ADDR0=01, _ADDR1=11 -> requester 0 served first, then requester 1 ({_B,_A}=11, _2G low), grant start 5 clocks apart; _1G and _2G never both low.
- Alternation: both REQs held high for 6 transactions -> grant order 0,1,0,1,0,1, each ACK exactly one cycle.
- Reset mid-STROBE: assert _RST_N=0 while _2G=0 -> _2G=1 within the same cycle (async), no _ACK1; after release with _REQ1 still high, a fresh transaction completes.
- LS155_DEMUX_EN: _REQ0=1, _ADDR0=00, _DATA0=0 -> _1G pulses low but _1C=0, so ls155 _1Y0 stays 1. Repeat with _DATA0=1 -> _1Y0=0 for 2 cycles.

Source files
------------

// File: rtl/ls155_arbiter.sv
// ls155_arbiter: two-requester front end for one SN74LS155 dual 2-to-4 decoder.
// Both decoder halves share the A/B select lines, so exactly one half is
// strobed per transaction: requester 0 drives half 1, requester 1 drives half 2.
// Each grant runs select setup, an enable strobe, and one hold cycle.
// The shared pointer alternates grants when both requesters are waiting.
// Optional feature macro: LS155_DEMUX_EN. It adds _DATA0/_DATA1 and drives the
// C inputs from the latched data, so the selected output goes low only when
// data=1 (demultiplexer mode).
module ls155_arbiter #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic       _CLK,
    input  logic       _RST_N,
    input  logic       _REQ0,
    input  logic [1:0] _ADDR0,
`ifdef LS155_DEMUX_EN
    input  logic       _DATA0,
`endif
    output logic       _ACK0,
    input  logic       _REQ1,
    input  logic [1:0] _ADDR1,
`ifdef LS155_DEMUX_EN
    input  logic       _DATA1,
`endif
    output logic       _ACK1,
    output logic       _A,
    output logic       _B,
    output logic       _1C,
    output logic       _1G,
    output logic       _2C,
    output logic       _2G,
    output logic       _BUSY
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

    // Counters run from N-1 down to 0, so a phase lasts exactly N clocks.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    // Most recent grant. It also identifies the owner of the transaction in flight.
    // Reset value 1 makes requester 0 win the first tie.
    logic       gnt;
    logic       gsel;

    // Winner for this IDLE cycle. A tie goes to the requester not served last.
    always_comb begin
        gsel = _REQ1;
        if (_REQ0 && _REQ1) gsel = ~gnt;
    end

    // Transaction sequencer. All decoder pins are registered here.
    // Reset forces both enables high at once, without waiting for a clock edge.
    always_ff @(posedge _CLK or negedge _RST_N) begin
        if (!_RST_N) begin
            state <= IDLE;
            cnt   <= 4'd0;
            gnt   <= 1'b1;
            _A    <= 1'b0;
            _B    <= 1'b0;
            _1G   <= 1'b1;
            _2G   <= 1'b1;
            _1C   <= 1'b1;
            _2C   <= 1'b0;
            _ACK0 <= 1'b0;
            _ACK1 <= 1'b0;
            _BUSY <= 1'b0;
        end else begin
            _ACK0 <= 1'b0;
            _ACK1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (_REQ0 || _REQ1) begin
                        gnt      <= gsel;
                        {_B, _A} <= gsel ? _ADDR1 : _ADDR0;
                        cnt      <= SETUP_LD;
                        state    <= SETUP;
                        _BUSY    <= 1'b1;
`ifdef LS155_DEMUX_EN
                        if (gsel) _2C <= ~_DATA1;
                        else      _1C <= _DATA0;
`endif
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        if (gnt) _2G <= 1'b0;
                        else     _1G <= 1'b0;
                        cnt   <= STROBE_LD;
                        state <= STROBE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        _1G <= 1'b1;
                        _2G <= 1'b1;
                        if (gnt) _ACK1 <= 1'b1;
                        else     _ACK0 <= 1'b1;
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RELEASE: begin
                    // A/B stay put for hold time. C returns to decoder mode.
                    _1C   <= 1'b1;
                    _2C   <= 1'b0;
                    _BUSY <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
